// File: rtl/dest_ctrl_pkg.sv
// dest_ctrl_pkg: shared types and default widths for the PIM destination
// address sequencer (dest_seq_ctrl) and its round-robin arbiter.
package dest_ctrl_pkg;

  localparam int DEST_N_DEF     = 10;
  localparam int DEST_LEN_W_DEF = 6;

  // Bit positions inside the one-hot arbiter select vector
  localparam int SEL_PIM = 0;
  localparam int SEL_MOV = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dest_state_t;

  typedef enum logic {
    REQ_PIM = 1'b0,
    REQ_MOV = 1'b1
  } dest_req_t;

endpackage

// File: rtl/dest_rr_arb.sv
// dest_rr_arb: 2-way round-robin arbiter between PIM burst and MOV requests.
// On contention the requester that was not served last wins. Output is a
// one-hot select (bit SEL_PIM / SEL_MOV), all zero when disabled.
module dest_rr_arb
  import dest_ctrl_pkg::*;
(
  input  logic       pim_req_i,
  input  logic       mov_req_i,
  input  dest_req_t  last_i,
  input  logic       en_i,
  output logic [1:0] sel_o
);

  // Combinational round-robin pick
  always_comb begin
    sel_o = 2'b00;
    if (en_i) begin
      if (pim_req_i && (!mov_req_i || (last_i == REQ_MOV))) begin
        sel_o[SEL_PIM] = 1'b1;
      end else if (mov_req_i) begin
        sel_o[SEL_MOV] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dest_seq_ctrl.sv
// dest_seq_ctrl: sequencer/arbiter for the PIM destination-address register.
// Serves PIM bursts (base load followed by one increment per completed row-op)
// and MOV single loads, drives the load/update strobes with their data, and
// keeps a shadow copy of the destination register.
// Optional build macro DEST_WRAP_CHK_EN enables the sticky wrap_err flag that
// records an increment issued while the register holds its maximum value.
module dest_seq_ctrl
  import dest_ctrl_pkg::*;
#(
  parameter int N     = DEST_N_DEF,
  parameter int LEN_W = DEST_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pim_req,
  input  logic [N-1:0]     pim_addr,
  input  logic [LEN_W-1:0] pim_len,
  output logic             pim_gnt,
  input  logic             mov_req,
  input  logic [N-1:0]     mov_addr,
  output logic             mov_gnt,
  input  logic             step_en,
  output logic             PIM_load,
  output logic             Mov_load,
  output logic             Update_load,
  output logic [N-1:0]     D_out,
  output logic [N-1:0]     MOV_out,
  output logic [N-1:0]     dest_addr,
  output logic             busy,
  output logic             done,
  output logic             wrap_err
);

  dest_state_t      state_q;
  dest_req_t        last_q;
  logic [LEN_W-1:0] cnt_q;
  logic             pim_gnt_q;
  logic             mov_gnt_q;
  logic             pim_load_q;
  logic             mov_load_q;
  logic             upd_q;
  logic             done_q;
  logic [N-1:0]     d_out_q;
  logic [N-1:0]     mov_out_q;
  logic [N-1:0]     dest_q;
  logic [1:0]       sel;

  // A MOV grant leaves the FSM in IDLE while the requester is still dropping
  // its request, so mask that request for the grant cycle to avoid re-serving it.
  dest_rr_arb u_arb (
    .pim_req_i (pim_req),
    .mov_req_i (mov_req && !mov_gnt_q),
    .last_i    (last_q),
    .en_i      (state_q == IDLE),
    .sel_o     (sel)
  );

  // Control FSM with registered grants, strobes and strobe data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= REQ_MOV;
      cnt_q      <= '0;
      pim_gnt_q  <= 1'b0;
      mov_gnt_q  <= 1'b0;
      pim_load_q <= 1'b0;
      mov_load_q <= 1'b0;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
      d_out_q    <= '0;
      mov_out_q  <= '0;
    end else begin
      pim_gnt_q  <= 1'b0;
      mov_gnt_q  <= 1'b0;
      pim_load_q <= 1'b0;
      mov_load_q <= 1'b0;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel[SEL_PIM]) begin
            pim_gnt_q  <= 1'b1;
            pim_load_q <= (pim_len != '0);
            d_out_q    <= pim_addr;
            cnt_q      <= pim_len - LEN_W'(1);
            last_q     <= REQ_PIM;
            if (pim_len >= LEN_W'(2)) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (sel[SEL_MOV]) begin
            mov_gnt_q  <= 1'b1;
            mov_load_q <= 1'b1;
            mov_out_q  <= mov_addr;
            last_q     <= REQ_MOV;
          end
        end
        RUN: begin
          if (step_en) begin
            upd_q <= 1'b1;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Shadow of the destination register, following the strobes one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
    end else if (pim_load_q) begin
      dest_q <= d_out_q;
    end else if (mov_load_q) begin
      dest_q <= mov_out_q;
    end else if (upd_q) begin
      dest_q <= dest_q + N'(1);
    end
  end

`ifdef DEST_WRAP_CHK_EN
  logic wrap_q;

  // Sticky wrap flag: set by an increment from all-ones, cleared by the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else if (upd_q && (dest_q == '1)) begin
      wrap_q <= 1'b1;
    end else if (sel != 2'b00) begin
      wrap_q <= 1'b0;
    end
  end

  assign wrap_err = wrap_q;
`else
  assign wrap_err = 1'b0;
`endif

  assign pim_gnt     = pim_gnt_q;
  assign mov_gnt     = mov_gnt_q;
  assign PIM_load    = pim_load_q;
  assign Mov_load    = mov_load_q;
  assign Update_load = upd_q;
  assign done        = done_q;
  assign D_out       = d_out_q;
  assign MOV_out     = mov_out_q;
  assign dest_addr   = dest_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dest_seq_ctrl.sv
// tb_dest_seq_ctrl: directed bench for dest_seq_ctrl. Control outputs are
// compared as a packed vector {pim_gnt, mov_gnt, PIM_load, Mov_load,
// Update_load, done, busy}, sampled 1 time unit after each rising edge.
module tb_dest_seq_ctrl;

  localparam int N     = 10;
  localparam int LEN_W = 6;

`ifdef DEST_WRAP_CHK_EN
  localparam logic WRAP_EXP = 1'b1;
`else
  localparam logic WRAP_EXP = 1'b0;
`endif

  // Control vector encodings
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_BUSY  = 7'b000_0001;
  localparam logic [6:0] C_MOVG  = 7'b010_1000;
  localparam logic [6:0] C_PIMG  = 7'b101_0001;
  localparam logic [6:0] C_PIMG1 = 7'b101_0011;
  localparam logic [6:0] C_PIMG0 = 7'b100_0011;
  localparam logic [6:0] C_UPD   = 7'b000_0101;
  localparam logic [6:0] C_UPDD  = 7'b000_0111;

  logic             clk;
  logic             rst_n;
  logic             pim_req;
  logic [N-1:0]     pim_addr;
  logic [LEN_W-1:0] pim_len;
  logic             pim_gnt;
  logic             mov_req;
  logic [N-1:0]     mov_addr;
  logic             mov_gnt;
  logic             step_en;
  logic             PIM_load;
  logic             Mov_load;
  logic             Update_load;
  logic [N-1:0]     D_out;
  logic [N-1:0]     MOV_out;
  logic [N-1:0]     dest_addr;
  logic             busy;
  logic             done;
  logic             wrap_err;

  int n_assert = 0;
  int n_fail   = 0;

  dest_seq_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pim_req     (pim_req),
    .pim_addr    (pim_addr),
    .pim_len     (pim_len),
    .pim_gnt     (pim_gnt),
    .mov_req     (mov_req),
    .mov_addr    (mov_addr),
    .mov_gnt     (mov_gnt),
    .step_en     (step_en),
    .PIM_load    (PIM_load),
    .Mov_load    (Mov_load),
    .Update_load (Update_load),
    .D_out       (D_out),
    .MOV_out     (MOV_out),
    .dest_addr   (dest_addr),
    .busy        (busy),
    .done        (done),
    .wrap_err    (wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {pim_gnt, mov_gnt, PIM_load, Mov_load, Update_load, done, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs
    rst_n    = 1'b0;
    pim_req  = 1'($urandom);
    mov_req  = 1'($urandom);
    pim_addr = N'($urandom);
    mov_addr = N'($urandom);
    pim_len  = LEN_W'($urandom);
    step_en  = 1'($urandom);
    step(); step();
    chk("rst_ctl", 32'(ctl()), 32'(C_NONE));
    chk("rst_dest", 32'(dest_addr), 32'h0);
    chk("rst_dout", 32'(D_out), 32'h0);
    chk("rst_movout", 32'(MOV_out), 32'h0);
    chk("rst_wrap", 32'(wrap_err), 32'h0);
    pim_req = 1'b0; mov_req = 1'b0; step_en = 1'b0;
    rst_n = 1'b1;
    step(); step();
    chk("idle_no_req", 32'(ctl()), 32'(C_NONE));

    // PIM burst 0x3FE, len 3, step_en high: wraps through 0x3FF to 0x000
    pim_req = 1'b1; pim_addr = 10'h3FE; pim_len = 6'd3; step_en = 1'b1;
    step();
    chk("p3_gnt", 32'(ctl()), 32'(C_PIMG));
    chk("p3_dout", 32'(D_out), 32'h3FE);
    pim_req = 1'b0;
    step();
    chk("p3_upd1", 32'(ctl()), 32'(C_UPD));
    chk("p3_dest0", 32'(dest_addr), 32'h3FE);
    step();
    chk("p3_upd2_done", 32'(ctl()), 32'(C_UPDD));
    chk("p3_dest1", 32'(dest_addr), 32'h3FF);
    step();
    chk("p3_idle", 32'(ctl()), 32'(C_NONE));
    chk("p3_dest2", 32'(dest_addr), 32'h000);
    chk("p3_wrap", 32'(wrap_err), 32'(WRAP_EXP));
    step_en = 1'b0;

    // MOV only 0x155; grant also clears the wrap flag
    mov_req = 1'b1; mov_addr = 10'h155;
    step();
    chk("mov_gnt", 32'(ctl()), 32'(C_MOVG));
    chk("mov_out", 32'(MOV_out), 32'h155);
    chk("mov_wrap_clr", 32'(wrap_err), 32'h0);
    mov_req = 1'b0;
    step();
    chk("mov_after", 32'(ctl()), 32'(C_NONE));
    chk("mov_dest", 32'(dest_addr), 32'h155);

    // Both requests held from reset: PIM (len 1) first, MOV 2 cycles after done
    rst_n = 1'b0;
    #1;
    chk("rst2_dest", 32'(dest_addr), 32'h0);
    pim_req = 1'b1; pim_addr = 10'h0A0; pim_len = 6'd1;
    mov_req = 1'b1; mov_addr = 10'h050;
    step();
    rst_n = 1'b1;
    step();
    chk("both_pim_first", 32'(ctl()), 32'(C_PIMG1));
    pim_req = 1'b0;
    step();
    chk("both_gap", 32'(ctl()), 32'(C_NONE));
    chk("both_dest_pim", 32'(dest_addr), 32'h0A0);
    step();
    chk("both_mov_second", 32'(ctl()), 32'(C_MOVG));
    chk("both_movout", 32'(MOV_out), 32'h050);
    mov_req = 1'b0;
    step();
    chk("both_dest_mov", 32'(dest_addr), 32'h050);

    // Lone PIM grant, then both requests: MOV wins, PIM follows immediately
    pim_req = 1'b1; pim_addr = 10'h011; pim_len = 6'd1;
    step();
    chk("rr_pim_alone", 32'(ctl()), 32'(C_PIMG1));
    pim_addr = 10'h022; mov_req = 1'b1; mov_addr = 10'h033;
    step();
    chk("rr_wait", 32'(ctl()), 32'(C_NONE));
    step();
    chk("rr_mov_wins", 32'(ctl()), 32'(C_MOVG));
    chk("rr_movout", 32'(MOV_out), 32'h033);
    mov_req = 1'b0;
    step();
    chk("rr_pim_next", 32'(ctl()), 32'(C_PIMG1));
    chk("rr_dout", 32'(D_out), 32'h022);
    pim_req = 1'b0;
    step();
    chk("rr_dest", 32'(dest_addr), 32'h022);

    // PIM len 4 with step_en pattern 1,0,0,1,1
    pim_req = 1'b1; pim_addr = 10'h100; pim_len = 6'd4; step_en = 1'b0;
    step();
    chk("tg_gnt", 32'(ctl()), 32'(C_PIMG));
    pim_req = 1'b0; step_en = 1'b1;
    step();
    chk("tg_upd1", 32'(ctl()), 32'(C_UPD));
    chk("tg_dest0", 32'(dest_addr), 32'h100);
    step_en = 1'b0;
    step();
    chk("tg_hold1", 32'(ctl()), 32'(C_BUSY));
    chk("tg_dest1", 32'(dest_addr), 32'h101);
    step();
    chk("tg_hold2", 32'(ctl()), 32'(C_BUSY));
    step_en = 1'b1;
    step();
    chk("tg_upd2", 32'(ctl()), 32'(C_UPD));
    step();
    chk("tg_upd3_done", 32'(ctl()), 32'(C_UPDD));
    chk("tg_dest2", 32'(dest_addr), 32'h102);
    step_en = 1'b0;
    step();
    chk("tg_idle", 32'(ctl()), 32'(C_NONE));
    chk("tg_dest3", 32'(dest_addr), 32'h103);

    // PIM len 0: grant and done only
    pim_req = 1'b1; pim_addr = 10'h2AA; pim_len = 6'd0;
    step();
    chk("l0_gnt_done", 32'(ctl()), 32'(C_PIMG0));
    pim_req = 1'b0;
    step();
    chk("l0_idle", 32'(ctl()), 32'(C_NONE));
    chk("l0_dest", 32'(dest_addr), 32'h103);

    // Reset mid-RUN with cnt = 2
    pim_req = 1'b1; pim_addr = 10'h200; pim_len = 6'd3; step_en = 1'b0;
    step();
    chk("ab_gnt", 32'(ctl()), 32'(C_PIMG));
    pim_req = 1'b0;
    step();
    chk("ab_run", 32'(ctl()), 32'(C_BUSY));
    chk("ab_dest", 32'(dest_addr), 32'h200);
    rst_n = 1'b0;
    #1;
    chk("ab_rst_ctl", 32'(ctl()), 32'(C_NONE));
    chk("ab_rst_dest", 32'(dest_addr), 32'h0);
    chk("ab_rst_dout", 32'(D_out), 32'h0);
    step_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("ab_no_done", 32'(ctl()), 32'(C_NONE));

    // Next PIM served normally: 0x3FF len 2, increment wraps
    pim_req = 1'b1; pim_addr = 10'h3FF; pim_len = 6'd2;
    step();
    chk("nx_gnt", 32'(ctl()), 32'(C_PIMG));
    chk("nx_dout", 32'(D_out), 32'h3FF);
    pim_req = 1'b0;
    step();
    chk("nx_upd_done", 32'(ctl()), 32'(C_UPDD));
    chk("nx_dest0", 32'(dest_addr), 32'h3FF);
    step_en = 1'b0;
    step();
    chk("nx_idle", 32'(ctl()), 32'(C_NONE));
    chk("nx_dest1", 32'(dest_addr), 32'h000);
    chk("nx_wrap", 32'(wrap_err), 32'(WRAP_EXP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
